// File: rtl/nand3_chk_pkg.sv
// Shared types and constants for the NAND3 response checker.
// Imported by the checker top and its settle timer.
package nand3_chk_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    localparam logic [7:0] NAND3_TABLE = 8'b0111_1111;
    localparam int         VEC_W       = 3;
    localparam int         SETTLE_W    = 4;

    localparam logic [7:0] FULL_COVER  = 8'hFF;

endpackage

// File: rtl/nand3_chk_settle_timer.sv
// Loadable down-counter with a zero flag.
// Counts the settle delay between a vector strobe and its check.
module nand3_chk_settle_timer
    import nand3_chk_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    input  logic                dec,
    output logic                zero
);

    logic [SETTLE_W-1:0] cnt_q;
    logic [SETTLE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - SETTLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/nand3_response_checker.sv
// Observes a 3-input gate under test: checks each applied vector
// against EXP_TABLE after a settle delay and accumulates results.
module nand3_response_checker
    import nand3_chk_pkg::*;
#(
    parameter logic [7:0] EXP_TABLE = NAND3_TABLE,
    parameter int         SETTLE    = 1,
    parameter int         CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             vec_valid,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [7:0]       cover_mask,
    output logic             overrun,
    output logic             first_fail_vld,
    output logic [2:0]       first_fail_vec,
    output logic             first_fail_out
);

    localparam bit HAS_TIMER = (SETTLE != 0);

    state_e state_q;
    state_e state_d;

    logic [VEC_W-1:0] vec_q;
    logic [VEC_W-1:0] vec_d;
    logic [VEC_W-1:0] in_vec;
    logic [VEC_W-1:0] chk_vec;

    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_d;
    logic [CNT_W-1:0] vec_cnt_q;
    logic [CNT_W-1:0] vec_cnt_d;
    logic [7:0]       cover_q;
    logic [7:0]       cover_d;
    logic             overrun_q;
    logic             overrun_d;
    logic             pass_q;
    logic             pass_d;
    logic             ff_vld_q;
    logic             ff_vld_d;
    logic [VEC_W-1:0] ff_vec_q;
    logic [VEC_W-1:0] ff_vec_d;
    logic             ff_out_q;
    logic             ff_out_d;

    logic check_en;
    logic mismatch;
    logic active;

    assign in_vec = {a, b, c};
    assign active = (state_q == S_RUN) || (state_q == S_SETTLE);

    generate
        if (SETTLE == 0) begin : g_no_timer
            assign chk_vec  = in_vec;
            assign check_en = (state_q == S_RUN) && vec_valid;
        end else begin : g_timer
            localparam logic [SETTLE_W-1:0] LOAD_VAL =
                SETTLE_W'(SETTLE - 1);
            logic tmr_zero;

            nand3_chk_settle_timer u_timer (
                .clk      (clk),
                .rst_n    (rst_n),
                .clr      (start),
                .load     ((state_q == S_RUN) && vec_valid),
                .load_val (LOAD_VAL),
                .dec      (state_q == S_SETTLE),
                .zero     (tmr_zero)
            );

            assign chk_vec  = vec_q;
            assign check_en = (state_q == S_SETTLE) && tmr_zero;
        end
    endgenerate

    // Case inequality so an X/Z response is flagged in simulation.
    assign mismatch = (dut_out !== EXP_TABLE[chk_vec]);

    always_comb begin
        vec_d     = vec_q;
        err_cnt_d = err_cnt_q;
        vec_cnt_d = vec_cnt_q;
        cover_d   = cover_q;
        overrun_d = overrun_q;
        pass_d    = pass_q;
        ff_vld_d  = ff_vld_q;
        ff_vec_d  = ff_vec_q;
        ff_out_d  = ff_out_q;

        if (start) begin
            vec_d     = '0;
            err_cnt_d = '0;
            vec_cnt_d = '0;
            cover_d   = '0;
            overrun_d = 1'b0;
            pass_d    = 1'b0;
            ff_vld_d  = 1'b0;
            ff_vec_d  = '0;
            ff_out_d  = 1'b0;
        end else begin
            if ((state_q == S_RUN) && vec_valid) begin
                vec_d = in_vec;
            end
            if ((state_q == S_SETTLE) && vec_valid) begin
                overrun_d = 1'b1;
            end
            if (check_en) begin
                if (vec_cnt_q != '1) begin
                    vec_cnt_d = vec_cnt_q + CNT_W'(1);
                end
                cover_d[chk_vec] = 1'b1;
                if (mismatch) begin
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    if (!ff_vld_q) begin
                        ff_vld_d = 1'b1;
                        ff_vec_d = chk_vec;
                        ff_out_d = dut_out;
                    end
                end
            end
            // Verdict includes any check landing in the same cycle.
            if (active && stop) begin
                pass_d = (cover_d == FULL_COVER) && (err_cnt_d == '0);
            end else if (check_en && (cover_d == FULL_COVER)) begin
                pass_d = (err_cnt_d == '0);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (stop) begin
                        state_d = S_DONE;
                    end else if (check_en && (cover_d == FULL_COVER)) begin
                        state_d = S_DONE;
                    end else if (vec_valid && HAS_TIMER) begin
                        state_d = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (stop) begin
                        state_d = S_DONE;
                    end else if (check_en) begin
                        state_d = (cover_d == FULL_COVER) ? S_DONE : S_RUN;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q     <= '0;
            err_cnt_q <= '0;
            vec_cnt_q <= '0;
            cover_q   <= '0;
            overrun_q <= 1'b0;
            pass_q    <= 1'b0;
            ff_vld_q  <= 1'b0;
            ff_vec_q  <= '0;
            ff_out_q  <= 1'b0;
        end else begin
            vec_q     <= vec_d;
            err_cnt_q <= err_cnt_d;
            vec_cnt_q <= vec_cnt_d;
            cover_q   <= cover_d;
            overrun_q <= overrun_d;
            pass_q    <= pass_d;
            ff_vld_q  <= ff_vld_d;
            ff_vec_q  <= ff_vec_d;
            ff_out_q  <= ff_out_d;
        end
    end

    always_comb begin
        busy = active;
        done = (state_q == S_DONE);
    end

    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign vec_cnt        = vec_cnt_q;
    assign cover_mask     = cover_q;
    assign overrun        = overrun_q;
    assign first_fail_vld = ff_vld_q;
    assign first_fail_vec = ff_vec_q;
    assign first_fail_out = ff_out_q;

endmodule

// File: doc/nand3_response_checker.md
Name: nand3_response_checker

Overview:
- Hardware response checker for a 3-input NAND gate under test. It is the observing end of the gate's stimulus/response interface.
- Each applied vector {a,b,c} is captured on a valid strobe. After a programmable settle delay it samples the DUT output and compares it against an expected truth table.
- It accumulates error count, vector count and input-combination coverage, and records the first failing vector.
- It sits beside the gate in self-test builds and replaces the manual waveform inspection at the end of each run.

Parameters:
- EXP_TABLE, 8'b0111_1111, expected output indexed by {a,b,c}; the default is NAND3 (0 only at 3'b111).
- SETTLE, 1, cycles from vec_valid to sampling dut_out; legal range 0..15.
- CNT_W, 8, width of err_cnt and vec_cnt.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: clear results and begin a run.
- stop  in  1  one-cycle pulse: end the run early.
- vec_valid  in  1  a, b, c are the vector now being applied to the DUT.
- a, b, c  in  1 each  vector inputs (a is index MSB).
- dut_out  in  1  DUT output under check.
- busy  out  1  run in progress (RUN or SETTLE state).
- done  out  1  run finished; held until start or reset.
- pass  out  1  valid when done=1: full coverage and zero errors.
- err_cnt  out  CNT_W  mismatch count; saturates at all-ones.
- vec_cnt  out  CNT_W  checked-vector count; saturates at all-ones.
- cover_mask  out  8  bit i set once vector i has been checked.
- overrun  out  1  sticky: a vec_valid arrived during SETTLE and was dropped.
- first_fail_vld  out  1  a mismatch has been recorded.
- first_fail_vec  out  3  {a,b,c} of the first mismatch.
- first_fail_out  out  1  dut_out value at the first mismatch.

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE and drives every output to 0. This applies mid-run as well; no partial results survive.
- IDLE: vec_valid and stop are ignored. start clears all counters, masks and sticky flags, clears done and pass, and moves to RUN.
- RUN: on vec_valid, {a,b,c} is latched into vec_q.
  - SETTLE=0: the check happens in the same cycle using the current dut_out, and the state stays RUN.
  - SETTLE=N>0: the state moves to SETTLE with timer=N-1.
- SETTLE: the timer decrements each cycle. The check happens in the cycle where timer==0, sampling dut_out, and the state then returns to RUN.
  - Overall latency: the check occurs N cycles after the vec_valid cycle.
- Overrun: vec_valid while in SETTLE sets overrun and drops that vector; the in-flight check is unaffected.
- Check cycle (all updates registered at the end of that cycle):
  - vec_cnt increments (saturating) and cover_mask[vec_q] is set.
  - Mismatch is dut_out != EXP_TABLE[vec_q]. In simulation, X or Z on dut_out counts as a mismatch.
  - On mismatch, err_cnt increments (saturating). If first_fail_vld=0, first_fail_vld, first_fail_vec and first_fail_out are captured.
- Completion: if the check leaves cover_mask at 8'hFF, the next state is DONE, so done=1 in the following cycle. pass = (err_cnt==0) evaluated including this final check.
- stop in RUN or SETTLE:
  - Moves to DONE next cycle; pass = (cover_mask==8'hFF && err_cnt==0).
  - A pending SETTLE check is abandoned.
  - If stop coincides with a check cycle, the check is counted first.
- DONE: outputs hold. vec_valid and stop are ignored. start restarts exactly as from IDLE.
- start in RUN or SETTLE: restarts as from IDLE and takes priority over a coincident check or stop.
- Repeated vectors are counted and checked every time. Coverage only requires each of the 8 vectors at least once.

Decomposition:
- Package nand3_chk_pkg:
  - state enum {IDLE, RUN, SETTLE, DONE};
  - NAND3_TABLE = 8'b0111_1111;
  - VEC_W = 3;
  - SETTLE_W = 4.
- One sub-module, nand3_chk_settle_timer: loadable down-counter with a zero flag. Used only when SETTLE>0; bypassed by generate when SETTLE=0.

Test Plan:
1. Correct NAND3 model, vectors 000..111 at 10-cycle spacing, SETTLE=1 -> done=1, pass=1, err_cnt=0, vec_cnt=8, cover_mask=8'hFF, first_fail_vld=0.
2. Stuck-at-1 DUT model, same sweep -> err_cnt=1, first_fail_vec=3'b111, first_fail_out=1, pass=0.
3. Vector 000 applied three times, then 001..111 -> vec_cnt=10; done asserts only the cycle after the 111 check. With CNT_W=3, vec_cnt saturates at 7.
4. stop after vectors 000..100 -> done=1 next cycle, pass=0, cover_mask=8'h1F, vec_cnt=5.
5. SETTLE=3, second vec_valid two cycles after the first -> overrun=1, vec_cnt=1, first vector checked 3 cycles after its strobe.
6. rst_n low mid-run after 4 vectors -> all outputs 0 immediately, without a clock edge. Release, then start plus full sweep -> pass=1, vec_cnt=8.
